// File: rtl/bit_count_pkg.sv
// Shared widths and FSM state encoding for the bit-count sequencer.
package bit_count_pkg;

  localparam int A_WIDTH   = 8;
  localparam int RET_WIDTH = 4;
  localparam int N_WIDTH   = 4;
  localparam int TOT_WIDTH = 12;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_RUN     = 3'd3;
  localparam state_t ST_RESULT  = 3'd4;
  localparam state_t ST_RELEASE = 3'd5;
  localparam state_t ST_FINISH  = 3'd6;

endpackage

// File: rtl/result_accumulator.sv
// Captures each per-word bit count and keeps a saturating running total.
module result_accumulator #(
  parameter int RET_WIDTH = bit_count_pkg::RET_WIDTH,
  parameter int TOT_WIDTH = bit_count_pkg::TOT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_add_en,
  input  logic [RET_WIDTH-1:0] i_value,
  output logic [RET_WIDTH-1:0] o_result,
  output logic [TOT_WIDTH-1:0] o_total
);

  logic [RET_WIDTH-1:0] r_result;
  logic [TOT_WIDTH-1:0] r_total;
  logic [TOT_WIDTH:0]   w_sum;

  // One extra bit catches the carry so the total clamps instead of wrapping.
  assign w_sum = {1'b0, r_total} + (TOT_WIDTH+1)'(i_value);

  // Clear at batch start; on each add, latch the word count and accumulate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_result <= '0;
      r_total  <= '0;
    end else if (i_clear) begin
      r_total  <= '0;
    end else if (i_add_en) begin
      r_result <= i_value;
      r_total  <= w_sum[TOT_WIDTH] ? '1 : w_sum[TOT_WIDTH-1:0];
    end
  end

  assign o_result = r_result;
  assign o_total  = r_total;

endmodule

// File: rtl/bit_count_sequencer.sv
// Feeds a batch of operands through an external bit counter, one word at a
// time, and hands each count downstream while summing the batch total.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; latches batch length, clears total
// FETCH   | in_ready high; registers the next operand into cnt_a
// LOAD    | one cycle with cnt_s low and cnt_a stable so the counter loads
// RUN     | cnt_s high; waits for cnt_done, captures and adds the count
// RESULT  | out_valid high, counter held done until downstream accepts
// RELEASE | cnt_s low; waits for cnt_done to fall before the next word
// FINISH  | batch_done high until start is dropped
module bit_count_sequencer #(
  parameter int A_WIDTH   = bit_count_pkg::A_WIDTH,
  parameter int RET_WIDTH = bit_count_pkg::RET_WIDTH,
  parameter int N_WIDTH   = bit_count_pkg::N_WIDTH,
  parameter int TOT_WIDTH = bit_count_pkg::TOT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [N_WIDTH-1:0]   i_n_words,
  input  logic [A_WIDTH-1:0]   i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_cnt_s,
  output logic [A_WIDTH-1:0]   o_cnt_a,
  input  logic                 i_cnt_done,
  input  logic [RET_WIDTH-1:0] i_cnt_result,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [RET_WIDTH-1:0] o_out_result,
  output logic [TOT_WIDTH-1:0] o_total,
  output logic                 o_batch_done
);

  import bit_count_pkg::*;

  state_t               r_state;
  logic [N_WIDTH-1:0]   r_remaining;
  logic [A_WIDTH-1:0]   r_cnt_a;
  logic                 w_clear;
  logic                 w_add_en;

  assign w_clear  = (r_state == ST_IDLE) && i_start;
  assign w_add_en = (r_state == ST_RUN) && i_cnt_done;

  // Batch sequencing: state, words left in the batch, and operand register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_cnt_a     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_remaining <= i_n_words;
            r_state     <= (i_n_words == '0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (i_in_valid) begin
            r_cnt_a <= i_in_data;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_cnt_done) r_state <= ST_RESULT;
        end
        ST_RESULT: begin
          if (i_out_ready) begin
            r_remaining <= r_remaining - N_WIDTH'(1);
            r_state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!i_cnt_done) r_state <= (r_remaining == '0) ? ST_FINISH : ST_FETCH;
        end
        ST_FINISH: begin
          if (!i_start) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  result_accumulator #(
    .RET_WIDTH (RET_WIDTH),
    .TOT_WIDTH (TOT_WIDTH)
  ) u_acc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_clear),
    .i_add_en (w_add_en),
    .i_value  (i_cnt_result),
    .o_result (o_out_result),
    .o_total  (o_total)
  );

  // Outputs decode straight from the state so reset forces them low at once.
  assign o_in_ready   = (r_state == ST_FETCH);
  assign o_cnt_s      = (r_state == ST_RUN) || (r_state == ST_RESULT);
  assign o_out_valid  = (r_state == ST_RESULT);
  assign o_batch_done = (r_state == ST_FINISH);
  assign o_cnt_a      = r_cnt_a;

endmodule

// File: tb/tb_bit_count_sequencer.sv
// Bench for bit_count_sequencer: behavioural bit-counter models, directed
// scenarios and randomized batches checked against popcount arithmetic.
module tb_bit_count_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [3:0]  i_n_words;
  logic [7:0]  i_in_data;
  logic        i_in_valid;
  logic        i_out_ready;

  logic        o_in_ready, o_cnt_s, o_out_valid, o_batch_done;
  logic [7:0]  o_cnt_a;
  logic        i_cnt_done;
  logic [3:0]  i_cnt_result, o_out_result;
  logic [11:0] o_total;

  logic        s_in_ready, s_cnt_s, s_out_valid, s_batch_done, s_cnt_done;
  logic [7:0]  s_cnt_a;
  logic [3:0]  s_cnt_result, s_out_result, s_total;

  int n_err = 0;
  int n_chk = 0;
  int lat = 1;
  int rel = 0;
  logic [7:0] wq[$];

  always #5 i_clk = ~i_clk;

  bit_count_sequencer u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_n_words(i_n_words),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_cnt_s(o_cnt_s), .o_cnt_a(o_cnt_a), .i_cnt_done(i_cnt_done),
    .i_cnt_result(i_cnt_result), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_result(o_out_result),
    .o_total(o_total), .o_batch_done(o_batch_done)
  );

  bit_count_sequencer #(.TOT_WIDTH(4)) u_dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_n_words(i_n_words),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(s_in_ready),
    .o_cnt_s(s_cnt_s), .o_cnt_a(s_cnt_a), .i_cnt_done(s_cnt_done),
    .i_cnt_result(s_cnt_result), .o_out_valid(s_out_valid),
    .i_out_ready(i_out_ready), .o_out_result(s_out_result),
    .o_total(s_total), .o_batch_done(s_batch_done)
  );

  function automatic int pop8(input logic [7:0] v);
    int c = 0;
    for (int b = 0; b < 8; b++) c += int'(v[b]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit counter model: loads a while s is low, reports done lat cycles after
  // s rises, and keeps done high for rel cycles after s falls.
  int m_cnt, m_hold, t_cnt, t_hold;
  logic [7:0] m_op, t_op;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_cnt <= 0; m_hold <= 0; m_op <= '0;
    end else if (!o_cnt_s) begin
      m_op <= o_cnt_a; m_cnt <= 0;
      if (m_hold > 0) m_hold <= m_hold - 1;
    end else begin
      if (m_cnt < 1000) m_cnt <= m_cnt + 1;
      m_hold <= (m_cnt >= lat) ? rel : 0;
    end
  end
  assign i_cnt_done   = o_cnt_s ? (m_cnt >= lat) : (m_hold > 0);
  assign i_cnt_result = 4'(pop8(m_op));

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t_cnt <= 0; t_hold <= 0; t_op <= '0;
    end else if (!s_cnt_s) begin
      t_op <= s_cnt_a; t_cnt <= 0;
      if (t_hold > 0) t_hold <= t_hold - 1;
    end else begin
      if (t_cnt < 1000) t_cnt <= t_cnt + 1;
      t_hold <= (t_cnt >= lat) ? rel : 0;
    end
  end
  assign s_cnt_done   = s_cnt_s ? (t_cnt >= lat) : (t_hold > 0);
  assign s_cnt_result = 4'(pop8(t_op));

  // Protocol monitor, sampled mid-cycle.
  logic       prev_s = 1'b0, prev_ov = 1'b0;
  logic [7:0] prev_a = '0;
  logic [3:0] prev_res = '0;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_cnt_s && !prev_s) chk("load_cycle_a_stable", o_cnt_a, prev_a);
      if (o_in_ready) begin
        chk("fetch_after_done_low", i_cnt_done, 1'b0);
        chk("fetch_no_out_valid", o_out_valid, 1'b0);
      end
      if (o_out_valid) chk("result_cnt_s_high", o_cnt_s, 1'b1);
      if (o_out_valid && prev_ov) chk("out_result_stable", o_out_result, prev_res);
    end
    prev_s   = o_cnt_s;
    prev_a   = o_cnt_a;
    prev_ov  = o_out_valid;
    prev_res = o_out_result;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Runs one batch of n words from wq; rnd randomizes handshakes and drops
  // start mid-batch, bp holds out_ready low for 5 cycles on the first result.
  task automatic run_batch(input int n, input bit rnd, input bit bp);
    int idx = 0, k = 0, sum = 0, cyc = 0, bp_cnt = 0;
    bit seen_ir = 0, done = 0;
    logic [3:0] bp_res = '0;
    for (int j = 0; j < n; j++) sum += pop8(wq[j]);
    i_start   = 1'b1;
    i_n_words = 4'(n);
    for (cyc = 0; cyc < 800 && !done; cyc++) begin
      if (cyc >= 2 && rnd && $urandom_range(0, 7) == 0) i_start = 1'b0;
      i_in_valid  = (idx < n) && (!rnd || $urandom_range(0, 1) == 1);
      i_in_data   = (idx < n) ? wq[idx] : 8'($urandom);
      i_out_ready = !rnd || ($urandom_range(0, 2) != 0);
      if (bp && o_out_valid && bp_cnt < 5) begin
        i_out_ready = 1'b0;
        chk("bp_in_ready_low", o_in_ready, 1'b0);
        if (bp_cnt == 0) bp_res = o_out_result;
        else begin
          chk("bp_out_valid_hold", o_out_valid, 1'b1);
          chk("bp_cnt_s_hold", o_cnt_s, 1'b1);
          chk("bp_out_result_hold", o_out_result, bp_res);
        end
        bp_cnt++;
      end
      if (o_in_ready) seen_ir = 1'b1;
      if (o_in_ready && i_in_valid) idx++;
      if (o_out_valid && i_out_ready) begin
        if (k < n) chk("word_result", o_out_result, 32'(pop8(wq[k])));
        else chk("extra_result", 32'(k), 32'(n));
        k++;
      end
      step();
      if (o_batch_done) done = 1'b1;
    end
    chk("batch_done_reached", done, 1'b1);
    chk("word_count", k, n);
    chk("total", o_total, sum);
    chk("total_saturating", s_total, (sum > 15) ? 15 : sum);
    if (n == 0) begin
      chk("empty_no_in_ready", seen_ir, 1'b0);
      chk("empty_done_latency", cyc, 1);
    end
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    step();
    chk("batch_done_clears", o_batch_done, 1'b0);
    chk("total_holds", o_total, sum);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ok;
    i_rst = 1'b1; i_start = 1'b0; i_n_words = '0; i_in_data = '0;
    i_in_valid = 1'b0; i_out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", o_in_ready, 1'b0);
    chk("rst_cnt_s", o_cnt_s, 1'b0);
    chk("rst_cnt_a", o_cnt_a, 8'h00);
    chk("rst_out_valid", o_out_valid, 1'b0);
    chk("rst_out_result", o_out_result, 4'h0);
    chk("rst_total", o_total, 12'h000);
    chk("rst_batch_done", o_batch_done, 1'b0);
    i_rst = 1'b0;
    step();

    lat = 2; rel = 1;
    wq = {8'hFF, 8'h00, 8'hA5};
    run_batch(3, 1'b0, 1'b0);

    wq = {};
    run_batch(0, 1'b0, 1'b0);

    lat = 0; rel = 0;
    wq = {8'hFF, 8'hFF};
    run_batch(2, 1'b0, 1'b0);

    lat = 1; rel = 2;
    wq = {8'h6E};
    run_batch(1, 1'b0, 1'b1);

    // Abort a batch while the counter is running.
    lat = 20; rel = 0;
    i_start = 1'b1; i_n_words = 4'd1; i_in_data = 8'h3C;
    i_in_valid = 1'b1; i_out_ready = 1'b1;
    ok = 0;
    for (int c = 0; c < 50 && ok == 0; c++) begin
      step();
      if (o_cnt_s) ok = 1;
    end
    chk("reached_run", ok, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("abort_in_ready", o_in_ready, 1'b0);
    chk("abort_cnt_s", o_cnt_s, 1'b0);
    chk("abort_cnt_a", o_cnt_a, 8'h00);
    chk("abort_out_valid", o_out_valid, 1'b0);
    chk("abort_out_result", o_out_result, 4'h0);
    chk("abort_total", o_total, 12'h000);
    chk("abort_batch_done", o_batch_done, 1'b0);
    i_start = 1'b0; i_in_valid = 1'b0;
    step();
    i_rst = 1'b0;
    step();
    lat = 1;
    wq = {8'h0F};
    run_batch(1, 1'b0, 1'b0);

    for (int b = 0; b < 25; b++) begin
      int n;
      n   = (b % 6 == 5) ? 15 : $urandom_range(0, 6);
      lat = $urandom_range(0, 4);
      rel = $urandom_range(0, 3);
      wq  = {};
      for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
      run_batch(n, 1'b1, (b % 4 == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
